sigdel_seq: RTL and testbench
=============================

Name: sigdel_seq

Overview:
Conversion scheduler for the passive sigma-delta ADC. Two requesters share the ADC under round-robin arbitration. For each granted request the block drives the 6-bit rate/oversampling/filter configuration and discards the decimation windows the selected filter needs to settle. It then captures one 16-bit filter result and returns it over a valid/ready result port.

Parameters:
EXTRA_SETTLE, 0, additional decimation windows discarded after every reconfiguration (0..15)
TO_W, 20, width of watchdog counter (timeout = 2^TO_W - 1 clk cycles); used only with the optional feature

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
req0_valid  input  1  requester 0 wants a conversion
req0_cfg  input  6  requester 0 config: [1:0] sample-rate div, [3:2] oversampling, [5:4] filter (00 AVG, 01 SINC1, 10 SINC2, 11 SINC3)
req0_ready  output  1  one-cycle accept pulse for requester 0
req1_valid  input  1  requester 1 wants a conversion
req1_cfg  input  6  as req0_cfg
req1_ready  output  1  one-cycle accept pulse for requester 1
dec_stb  input  1  decimation strobe from the ADC datapath, one cycle per output window
adc_data  input  16  selected filter output, valid from the cycle after dec_stb
cfg_out  output  6  drives ADC config bits inp[6:1]
res_valid  output  1  result available
res_ready  input  1  consumer accepts result
res_data  output  16  captured conversion value
res_id  output  1  requester index of res_data
res_err  output  1  result aborted by timeout (constant 0 without optional feature)
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE, cfg_out=0, res_valid=0, res_data=0, res_id=0, res_err=0, req*_ready=0, rr pointer=0 (requester 0 preferred), settle count=0. Reset mid-operation abandons any conversion; no result is produced.
- FSM states: IDLE, GRANT, SETTLE, WAIT, CAPTURE, RESP.
- IDLE: if exactly one reqX_valid, select it. If both, select the requester not equal to the rr pointer. Go to GRANT.
- GRANT (1 cycle):
  - pulse the selected reqX_ready; the handshake completes in this cycle
  - latch reqX_cfg into cfg_out; record index into res_id; set rr pointer to that index
  - load settle count = filter settle (AVG 1, SINC1 1, SINC2 2, SINC3 3) + EXTRA_SETTLE
  - go to SETTLE
- SETTLE: each dec_stb decrements the count. A dec_stb that drops the count from 1 to 0 moves to WAIT. Strobes in GRANT and in the first SETTLE cycle count normally (no masking).
- WAIT: the next dec_stb moves to CAPTURE.
- CAPTURE (1 cycle): res_data<=adc_data, res_err<=0, res_valid<=1, go to RESP.
- RESP: hold res_valid, res_data, res_id until res_valid&&res_ready, then res_valid<=0 and go to IDLE. A new grant cannot occur in the same cycle; earliest next reqX_ready is 2 cycles after the result handshake.
- cfg_out holds its value after completion until the next GRANT. It is never changed outside GRANT.
- Minimum latency: GRANT to res_valid = (settle+1) strobe periods + 1 cycle.
- reqX_cfg is sampled only in GRANT. Changes while valid but not granted are permitted. req valid deasserted before grant → no grant.
- Count arithmetic is 5-bit unsigned; max 3+15=18, no wrap.

Optional Feature:
SIGDEL_SEQ_TIMEOUT_EN:
- Defined: a TO_W-bit watchdog clears on GRANT and on every dec_stb, and increments in SETTLE/WAIT. On reaching all-ones the FSM goes to RESP with res_data=16'hFFFF, res_err=1, res_valid=1.
- Undefined: no watchdog; res_err tied 0; SETTLE/WAIT wait indefinitely for dec_stb.

Test Plan:
- Single request: req0_cfg=6'b110000 (SINC3), dec_stb every 16 cycles, adc_data=16'h1234 → req0_ready pulses once; cfg_out=6'b110000; 3 strobes discarded; capture on 4th strobe; res_data=16'h1234, res_id=0.
- Arbitration: both valid continuously, rr=0 after reset → grants 1,0,1,0 over four conversions; each req*_ready is one cycle wide.
- Backpressure: res_ready=0 for 50 cycles after res_valid → res_data stable, no new grant, busy=1. res_ready=1 → res_valid drops next cycle; next grant 2 cycles later.
- Settle counts: AVG with EXTRA_SETTLE=2 → 3 strobes discarded. SINC2 with EXTRA_SETTLE=0 → 2 discarded. Strobe coincident with GRANT is counted.
- Reset mid-SETTLE: rst=1 for 1 cycle → all outputs 0, state IDLE, no res_valid afterwards without a new request.
- With SIGDEL_SEQ_TIMEOUT_EN, TO_W=6, no dec_stb after grant → res_valid after 63 cycles, res_err=1, res_data=16'hFFFF.

Source files
------------

// File: rtl/sigdel_seq.sv
// Sigma-delta ADC conversion scheduler: round-robin over two requesters, settle-window discard, one captured result.
// Optional watchdog abort under `SIGDEL_SEQ_TIMEOUT_EN`.
module sigdel_seq #(
  parameter int EXTRA_SETTLE = 0,
  parameter int TO_W         = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [5:0]  req0_cfg,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [5:0]  req1_cfg,
  output logic        req1_ready,
  input  logic        dec_stb,
  input  logic [15:0] adc_data,
  output logic [5:0]  cfg_out,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_data,
  output logic        res_id,
  output logic        res_err,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, GRANT, SETTLE, WAIT, CAPTURE, RESP} state_t;

  localparam logic [4:0] EXTRA = 5'(EXTRA_SETTLE);

  if (TO_W < 1 || EXTRA_SETTLE < 0 || EXTRA_SETTLE > 15) begin : g_param_chk
    $error("sigdel_seq: TO_W must be >= 1 and EXTRA_SETTLE in 0..15");
  end

  state_t      state, state_nxt;
  logic        sel_q, sel_nxt;
  logic        rr_q;
  logic [4:0]  cnt_q;
  logic [5:0]  sel_cfg;
  logic [4:0]  load_cnt;
  logic        timeout;

  // Settle windows per filter: AVG/SINC1 one, SINC2 two, SINC3 three.
  always_comb begin
    sel_cfg = sel_q ? req1_cfg : req0_cfg;
    case (sel_cfg[5:4])
      2'b10:   load_cnt = 5'd2 + EXTRA;
      2'b11:   load_cnt = 5'd3 + EXTRA;
      default: load_cnt = 5'd1 + EXTRA;
    endcase
  end

`ifdef SIGDEL_SEQ_TIMEOUT_EN
  logic [TO_W-1:0] wd_q;
  logic            err_q;
  assign timeout = (&wd_q) && !dec_stb && (state == SETTLE || state == WAIT);
  assign res_err = err_q;
`else
  assign timeout = 1'b0;
  assign res_err = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel_q;
    case (state)
      IDLE: begin
        if (req0_valid && req1_valid) begin
          sel_nxt   = ~rr_q;
          state_nxt = GRANT;
        end else if (req0_valid) begin
          sel_nxt   = 1'b0;
          state_nxt = GRANT;
        end else if (req1_valid) begin
          sel_nxt   = 1'b1;
          state_nxt = GRANT;
        end
      end
      GRANT:   state_nxt = (dec_stb && load_cnt == 5'd1) ? WAIT : SETTLE;
      SETTLE: begin
        if (timeout)                       state_nxt = RESP;
        else if (dec_stb && cnt_q == 5'd1) state_nxt = WAIT;
      end
      WAIT: begin
        if (timeout)      state_nxt = RESP;
        else if (dec_stb) state_nxt = CAPTURE;
      end
      CAPTURE: state_nxt = RESP;
      RESP:    if (res_valid && res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign req0_ready = (state == GRANT) && !sel_q;
  assign req1_ready = (state == GRANT) && sel_q;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sel_q     <= 1'b0;
      rr_q      <= 1'b0;
      cnt_q     <= 5'd0;
      cfg_out   <= 6'd0;
      res_valid <= 1'b0;
      res_data  <= 16'd0;
      res_id    <= 1'b0;
`ifdef SIGDEL_SEQ_TIMEOUT_EN
      wd_q      <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      sel_q <= sel_nxt;
      case (state)
        GRANT: begin
          cfg_out <= sel_cfg;
          res_id  <= sel_q;
          rr_q    <= sel_q;
          // A strobe landing in the grant cycle already counts as the first window.
          cnt_q   <= dec_stb ? load_cnt - 5'd1 : load_cnt;
        end
        SETTLE:  if (dec_stb) cnt_q <= cnt_q - 5'd1;
        CAPTURE: begin
          res_data  <= adc_data;
          res_valid <= 1'b1;
`ifdef SIGDEL_SEQ_TIMEOUT_EN
          err_q     <= 1'b0;
`endif
        end
        RESP:    if (res_valid && res_ready) res_valid <= 1'b0;
        default: ;
      endcase
`ifdef SIGDEL_SEQ_TIMEOUT_EN
      if (state == GRANT || dec_stb)
        wd_q <= '0;
      else if (state == SETTLE || state == WAIT)
        wd_q <= wd_q + 1'b1;
      if (timeout) begin
        res_data  <= 16'hFFFF;
        err_q     <= 1'b1;
        res_valid <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_sigdel_seq.sv
// Scoreboard bench for sigdel_seq: grants push expected results, a monitor pops them at each result handshake.
module tb_sigdel_seq;
  localparam int EXTRA = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic [5:0]  req0_cfg, req1_cfg;
  logic        req0_ready, req1_ready;
  logic        dec_stb;
  logic [15:0] adc_data;
  logic [5:0]  cfg_out;
  logic        res_valid, res_ready;
  logic [15:0] res_data;
  logic        res_id, res_err, busy;

  sigdel_seq #(.EXTRA_SETTLE(EXTRA), .TO_W(20)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_cfg(req0_cfg), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_cfg(req1_cfg), .req1_ready(req1_ready),
    .dec_stb(dec_stb), .adc_data(adc_data), .cfg_out(cfg_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_id(res_id), .res_err(res_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        id;
    logic [15:0] data;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   scnt = 0;
  int   period = 16;
  int   phase = 0;
  logic stb_en = 1'b0;
  int   last_hs = -100;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Strobe source: after strobe n, adc_data reads 16'h1230 + n.
  initial begin
    dec_stb  = 1'b0;
    adc_data = 16'h1230;
    forever begin
      @(posedge clk);
      #1;
      if (dec_stb) begin
        scnt++;
        adc_data = 16'h1230 + 16'(scnt);
      end
      phase   = (phase + 1 >= period) ? 0 : phase + 1;
      dec_stb = stb_en && (phase == 0);
    end
  end

  // Monitor: result handshakes, output stability while stalled, ready pulse shape.
  logic        prev_valid = 1'b0, prev_r0 = 1'b0, prev_r1 = 1'b0;
  logic [15:0] held_data;
  logic        held_id;
  exp_t        e;
  always @(negedge clk) begin
    if (!rst) begin
      if (req0_ready || req1_ready) check("ready_onehot", {31'd0, req0_ready & req1_ready}, 0);
      if (req0_ready) check("req0_ready_width", {31'd0, prev_r0}, 0);
      if (req1_ready) check("req1_ready_width", {31'd0, prev_r1}, 0);
      if (res_valid && prev_valid) begin
        check("res_data_stable", res_data, held_data);
        check("res_id_stable", res_id, held_id);
      end
      if (res_valid && res_ready) begin
        check("result_expected", (sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("res_data", res_data, e.data);
          check("res_id", res_id, e.id);
          check("res_err", res_err, e.err);
        end
        last_hs = cyc;
      end
    end
    prev_valid = res_valid && !res_ready;
    prev_r0    = req0_ready;
    prev_r1    = req1_ready;
    held_data  = res_data;
    held_id    = res_id;
  end

  // Waits for a grant, checks who got it, pushes the expected result, checks cfg_out next cycle.
  task automatic wait_grant(input int exp_id, input int base_settle, output int gcyc);
    int         n;
    bit         got;
    logic [5:0] c;
    n    = 0;
    got  = 0;
    gcyc = -1;
    while (!got && n < 400) begin
      @(negedge clk);
      n++;
      if (req0_ready || req1_ready) got = 1;
    end
    check("grant_seen", got, 1);
    if (got) begin
      gcyc = cyc;
      check("grant_id", req1_ready, exp_id);
      c = exp_id[0] ? req1_cfg : req0_cfg;
      sb.push_back('{id: exp_id[0], data: 16'h1230 + 16'(scnt + base_settle + EXTRA + 1), err: 1'b0});
      @(negedge clk);
      check("cfg_out", cfg_out, c);
      check("busy_after_grant", busy, 1);
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("result_done", sb.size(), 0);
  endtask

  task automatic single(input int id, input logic [5:0] cfg, input int base_settle);
    int g;
    if (id == 0) begin req0_cfg = cfg; req0_valid = 1'b1; end
    else         begin req1_cfg = cfg; req1_valid = 1'b1; end
    wait_grant(id, base_settle, g);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_done();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0d required=finish", cyc);
    $fatal(1, "simulation time limit");
  end

  initial begin
    int  g;
    bit  ok;
    bit  seen;
    int  n;
    logic [15:0] hold;
    rst        = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_cfg   = 6'd0;
    req1_cfg   = 6'd0;
    res_ready  = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_cfg_out", cfg_out, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_res_id", res_id, 0);
    check("rst_res_err", res_err, 0);
    check("rst_ready", {req0_ready, req1_ready}, 0);
    check("rst_busy", busy, 0);
    @(posedge clk); #1 rst = 1'b0;
    stb_en = 1'b1;

    // Single requests, one per filter, strobe every 16 cycles.
    single(0, 6'b110000, 3);
    single(1, 6'b000110, 1);
    single(0, 6'b101011, 2);
    single(1, 6'b011101, 1);

    // Strobe every cycle: grant cycle always coincides with a strobe.
    period = 1;
    single(0, 6'b111111, 3);
    single(1, 6'b001000, 1);
    period = 7;

    // Reset in the middle of SETTLE.
    req0_cfg   = 6'b100000;
    req0_valid = 1'b1;
    wait_grant(0, 2, g);
    req0_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("busy_in_settle", busy, 1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    sb.delete();
    @(negedge clk);
    check("midrst_cfg_out", cfg_out, 0);
    check("midrst_res_data", res_data, 0);
    check("midrst_busy", busy, 0);
    seen = 0;
    repeat (100) begin
      @(negedge clk);
      if (res_valid || busy) seen = 1;
    end
    check("no_activity_after_reset", seen, 0);

    // Arbitration with both requesters always pending: 1,0,1,0.
    req0_cfg   = 6'b010001;
    req1_cfg   = 6'b100100;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_grant((k % 2 == 0) ? 1 : 0, (k % 2 == 0) ? 2 : 1, g);
      if (k > 0) check("grant_gap", g - last_hs, 2);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_done();

    // Backpressure: hold res_ready low for 50 cycles with another request pending.
    @(posedge clk); #1 res_ready = 1'b0;
    req0_cfg   = 6'b000000;
    req0_valid = 1'b1;
    wait_grant(0, 1, g);
    req0_valid = 1'b0;
    n = 0;
    while (!res_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("bp_res_valid_seen", res_valid, 1);
    req1_cfg   = 6'b110110;
    req1_valid = 1'b1;
    hold = res_data;
    ok   = 1;
    repeat (50) begin
      @(negedge clk);
      if (!res_valid || res_data !== hold || !busy || req0_ready || req1_ready) ok = 0;
    end
    check("bp_hold", ok, 1);
    @(posedge clk); #1 res_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_valid_drop", res_valid, 0);
    wait_grant(1, 3, g);
    check("bp_grant_gap", g - last_hs, 2);
    req1_valid = 1'b0;
    wait_done();

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
